piso_seq_ctrl: RTL and testbench

Sequencing controller that accepts parallel words through a valid/ready handshake, captures each word into an internal parallel-load register, and drives it out one bit per cycle. The serial side has downstream backpressure. It sits between a parallel data producer and a single-bit link. It owns load, shift, and frame sequencing, so producers never drive the shift register directly.

---
 rtl/piso_seq_ctrl.sv | 100 ++++++++++
 tb/tb_piso_seq_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_seq_ctrl.sv
// rtl/piso_seq_ctrl.sv - valid/ready parallel-in serial-out sequencer (optional parity: PISO_PARITY_EN)
module piso_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int CW = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] data;
    logic             order;
    logic [CW-1:0]    cnt;
    logic             head;
    logic             bit_out;

    assign head = order ? data[WIDTH-1] : data[0];

`ifdef PISO_PARITY_EN
    logic par;

    // The parity bit trails the data bits once the counter has passed them.
    assign bit_out = (cnt == CW'(WIDTH)) ? par : head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par <= 1'b0;
        end else if (state == S_IDLE && in_valid) begin
            par <= ^in_data;
        end
    end
`else
    assign bit_out = head;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            data  <= '0;
            order <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        data  <= in_data;
                        order <= msb_first;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (sout_ready) begin
                        data  <= order ? {data[WIDTH-2:0], 1'b0} : {1'b0, data[WIDTH-1:1]};
                        cnt   <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // All handshake outputs decode from state alone, so no valid/ready combinational path exists.
    assign in_ready    = (state == S_IDLE);
    assign sout_valid  = (state == S_SHIFT);
    assign done        = (state == S_DONE);
    assign busy        = (state == S_SHIFT) || (state == S_DONE);
    assign frame_start = (state == S_SHIFT) && (cnt == '0);
    assign sout        = sout_valid & bit_out;

endmodule

// File: tb/tb_piso_seq_ctrl.sv
// tb/tb_piso_seq_ctrl.sv - self-checking bench for piso_seq_ctrl (vectors, corner sequences, random model)
module tb_piso_seq_ctrl;

`ifdef PISO_PARITY_EN
    localparam int L = 5;
`else
    localparam int L = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       msb_first;
    logic       sout;
    logic       sout_valid;
    logic       sout_ready;
    logic       frame_start;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    // seq: frame bits in transmit order, leftmost first, parity in seq[0]
    // st:  2-bit stall count in front of each bit, bit 0 in st[1:0]
    typedef struct {
        logic [3:0] d;
        logic       m;
        logic [4:0] seq;
        logic [9:0] st;
        bit         mid;
        bit         hold;
    } vec_t;

    vec_t vecs[7];

    piso_seq_ctrl #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .msb_first   (msb_first),
        .sout        (sout),
        .sout_valid  (sout_valid),
        .sout_ready  (sout_ready),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] model_seq(input logic [3:0] d, input logic m);
        logic [4:0] s;
        for (int i = 0; i < 4; i++) begin
            s[4-i] = m ? d[3-i] : d[i];
        end
        s[0] = ^d;
        return s;
    endfunction

    // Called at a falling edge; returns at the falling edge after in_ready reasserts.
    task automatic send_frame(input vec_t v, input string tag);
        int waitc;
        int stall;
        in_data    = v.d;
        msb_first  = v.m;
        in_valid   = 1'b1;
        sout_ready = 1'b0;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            check({tag, " accept_timeout"}, in_ready, 1'b1);
            in_valid = 1'b0;
        end else begin
            @(negedge clk);
            if (!v.hold) in_valid = 1'b0;
            check({tag, " in_ready_low"}, in_ready, 1'b0);
            for (int i = 0; i < L; i++) begin
                stall = int'(v.st[2*i +: 2]);
                for (int s = 0; s <= stall; s++) begin
                    sout_ready = (s == stall);
                    check($sformatf("%s sout[%0d]", tag, i), sout, v.seq[4-i]);
                    check($sformatf("%s sout_valid[%0d]", tag, i), sout_valid, 1'b1);
                    check($sformatf("%s frame_start[%0d]", tag, i), frame_start, i == 0);
                    check($sformatf("%s done_early[%0d]", tag, i), done, 1'b0);
                    check($sformatf("%s busy[%0d]", tag, i), busy, 1'b1);
                    @(negedge clk);
                    if (v.mid) begin
                        in_data   = ~in_data;
                        msb_first = ~msb_first;
                    end
                end
            end
            sout_ready = 1'b0;
            check({tag, " done"}, done, 1'b1);
            check({tag, " done_sout_valid"}, sout_valid, 1'b0);
            check({tag, " done_sout"}, sout, 1'b0);
            check({tag, " done_in_ready"}, in_ready, 1'b0);
            check({tag, " done_busy"}, busy, 1'b1);
            @(negedge clk);
            check({tag, " done_cleared"}, done, 1'b0);
            check({tag, " in_ready_back"}, in_ready, 1'b1);
            check({tag, " idle_busy"}, busy, 1'b0);
            if (!v.hold) in_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t rv;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 4'h0;
        msb_first  = 1'b0;
        sout_ready = 1'b0;

        #2;
        check("rst in_ready", in_ready, 1'b1);
        check("rst sout", sout, 1'b0);
        check("rst sout_valid", sout_valid, 1'b0);
        check("rst frame_start", frame_start, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = '{4'b1011, 1'b1, 5'b10111, 10'd0, 1'b0, 1'b0};
        vecs[1] = '{4'b1011, 1'b0, 5'b11011, 10'd0, 1'b0, 1'b0};
        vecs[2] = '{4'b0110, 1'b1, 5'b01100, {2'd0, 2'd0, 2'd2, 2'd0, 2'd3}, 1'b0, 1'b0};
        vecs[3] = '{4'hA,    1'b1, 5'b10100, 10'd0, 1'b0, 1'b1};
        vecs[4] = '{4'h5,    1'b1, 5'b01010, 10'd0, 1'b0, 1'b0};
        vecs[5] = '{4'b1100, 1'b0, 5'b00110, 10'd0, 1'b1, 1'b0};
        vecs[6] = '{4'b1001, 1'b1, 5'b10010, {2'd1, 2'd1, 2'd1, 2'd1, 2'd1}, 1'b1, 1'b0};
        for (int k = 0; k < 7; k++) begin
            send_frame(vecs[k], $sformatf("vec%0d", k));
        end

        // Reset two bits into a frame of 4'hF
        in_data    = 4'hF;
        msb_first  = 1'b1;
        in_valid   = 1'b1;
        sout_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst before sout_valid", sout_valid, 1'b1);
        check("midrst before frame_start", frame_start, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst in_ready", in_ready, 1'b1);
        check("midrst sout", sout, 1'b0);
        check("midrst sout_valid", sout_valid, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst done", done, 1'b0);
        check("midrst frame_start", frame_start, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        sout_ready = 1'b0;
        @(negedge clk);
        check("postrst done", done, 1'b0);
        check("postrst in_ready", in_ready, 1'b1);
        rv = '{4'h3, 1'b1, 5'b00110, 10'd0, 1'b0, 1'b0};
        send_frame(rv, "after_rst");

        for (int r = 0; r < 25; r++) begin
            rv.d    = 4'($urandom_range(0, 15));
            rv.m    = 1'($urandom_range(0, 1));
            rv.seq  = model_seq(rv.d, rv.m);
            rv.st   = 10'($urandom_range(0, 1023));
            rv.mid  = 1'($urandom_range(0, 1));
            rv.hold = 1'b0;
            send_frame(rv, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
